// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } ifu_state_t;

  localparam logic [31:0] PC_STEP        = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;
  localparam logic [31:0] PC_ALIGN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/ifu_queue.sv
// Instruction queue: synchronous FIFO of fetch entries with flush and a registered head,
// so the head output is steady while the queue is stalled and holds its last value when empty.
module ifu_queue
  import ifu_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         enq,
  input  fetch_entry_t                 enq_data,
  input  logic                         deq,
  output fetch_entry_t                 head,
  output logic [$clog2(QDEPTH+1)-1:0]  count
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  fetch_entry_t  mem [QDEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          bypass;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(QDEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    rd_nxt  = deq ? ptr_inc(rd_ptr) : rd_ptr;
    cnt_nxt = count;
    if (enq && !deq)
      cnt_nxt = count + CW'(1);
    else if (deq && !enq)
      cnt_nxt = count - CW'(1);
    // The incoming word becomes the head when nothing older remains after this dequeue.
    bypass = enq && (count == CW'(deq));
  end

  always_ff @(posedge clk) begin
    if (enq && !flush)
      mem[wr_ptr] <= enq_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)
        wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      if (cnt_nxt != '0)
        head <= bypass ? enq_data : mem[rd_nxt];
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, fetch FSM, single-outstanding memory issue and instruction queue.
// Optional IFU_PERF_EN adds fetch_cnt/flush_cnt performance counters.
//
//   state   | meaning
//   IDLE    | first cycle after reset release, no request
//   FETCH   | normal issue / enqueue
//   DISCARD | redirected with a request in flight; its data is dropped on ack
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus8,
  output logic        instr_valid,
  input  logic        instr_ready
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int CW = $clog2(QDEPTH + 1);

  ifu_state_t    state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic          pending;
  logic [CW-1:0] count;
  logic          deq_raw;
  logic          room;
  logic          enq;
  logic          deq;
  fetch_entry_t  head;
  fetch_entry_t  enq_data;

  assign deq_raw  = instr_valid && instr_ready;
  assign room     = (count < CW'(QDEPTH)) || deq_raw;
  // Once issued, a request is held until acked, regardless of state or redirect.
  assign imem_req  = pending || ((state == FETCH) && room);
  assign imem_addr = pending ? req_addr : fetch_pc;

  assign enq      = imem_req && imem_ack && (state == FETCH) && !pc_src;
  assign deq      = deq_raw && !pc_src;
  assign enq_data = '{pc: fetch_pc, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      pending  <= 1'b0;
    end else begin
      pending  <= imem_req && !imem_ack;
      req_addr <= imem_addr;
      if (pc_src) begin
        fetch_pc <= branch_target & PC_ALIGN_MASK;
        state    <= (imem_req && !imem_ack) ? DISCARD : FETCH;
      end else begin
        case (state)
          IDLE:    state <= FETCH;
          FETCH:   if (enq) fetch_pc <= fetch_pc + PC_STEP;
          DISCARD: if (imem_ack) state <= FETCH;
          default: state <= IDLE;
        endcase
      end
    end
  end

  ifu_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (pc_src),
    .enq      (enq),
    .enq_data (enq_data),
    .deq      (deq),
    .head     (head),
    .count    (count)
  );

  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign pc_plus8    = head.pc + PC_READ_OFFSET;

`ifdef IFU_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (enq)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (pc_src)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed table, random traffic against a transaction-level
// model, and hand sequences for stall, slow memory, discard and reset corner cases.
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  localparam int          QDEPTH   = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        pc_src;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus8;
  logic        instr_valid;
  logic        instr_ready;
`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  instr_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc_plus8      (pc_plus8),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready)
`ifdef IFU_PERF_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model state
  fetch_entry_t mq[$];
  logic [31:0]  mpc;
  logic [31:0]  held_addr;
  bit           inflight;
  bit           stale;
  bit           idle;
  int           wait_cnt;
  int           cur_lat;
  int           lat_fixed;
  int           delivered;

  typedef struct {
    logic        rdy;
    logic        psc;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ipc;
  } vec_t;
  vec_t tbl[10];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} + 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_init();
    mq.delete();
    mpc       = RESET_PC;
    inflight  = 0;
    stale     = 0;
    idle      = 1;
    wait_cnt  = 0;
  endtask

  task automatic cyc_begin(input logic r, input logic p, input logic [31:0] t);
    logic exp_req;
    int   ndeq;
    instr_ready   = r;
    pc_src        = p;
    branch_target = t;
    #1;
    if (imem_req) begin
      if (wait_cnt == 0)
        cur_lat = (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
      if (wait_cnt >= cur_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mdata(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wait_cnt++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end
    @(negedge clk);
    chk("valid", 32'(instr_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("instr", instr, mq[0].instr);
      chk("instr_pc", instr_pc, mq[0].pc);
      chk("pc_plus8", pc_plus8, mq[0].pc + 32'd8);
    end
    if (idle) begin
      chk("req_idle", 32'(imem_req), 32'd0);
    end else if (inflight) begin
      chk("req_hold", 32'(imem_req), 32'd1);
      chk("addr_hold", imem_addr, held_addr);
    end else begin
      if (!pc_src) begin
        ndeq    = ((mq.size() > 0) && instr_ready) ? 1 : 0;
        exp_req = (mq.size() - ndeq) < QDEPTH;
        chk("req", 32'(imem_req), 32'(exp_req));
      end
      if (imem_req)
        chk("addr", imem_addr, mpc);
    end
  endtask

  task automatic cyc_end();
    fetch_entry_t e;
    bit mdeq;
    mdeq = (mq.size() > 0) && instr_ready && !pc_src;
    if (pc_src) begin
      mq.delete();
      mpc   = {branch_target[31:2], 2'b00};
      stale = imem_req && !imem_ack;
    end else begin
      if (mdeq) begin
        void'(mq.pop_front());
        delivered++;
      end
      if (imem_req && imem_ack) begin
        if (stale) begin
          stale = 0;
        end else begin
          e.pc    = mpc;
          e.instr = imem_rdata;
          mq.push_back(e);
          mpc = mpc + 32'd4;
        end
      end
    end
    if (imem_req && !imem_ack) begin
      inflight  = 1;
      held_addr = imem_addr;
    end else begin
      inflight = 0;
    end
    idle = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic r, input logic p, input logic [31:0] t);
    cyc_begin(r, p, t);
    cyc_end();
  endtask

  initial begin
    logic [31:0] rec_pc;
    logic [31:0] first_addr;
    bit          got_addr;
    bit          got_valid;
    int          d0;

    //            rdy   psc   tgt           req   addr          vld   ipc
    tbl[0] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0000, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b1, 32'h4};
    tbl[4] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_000C, 1'b1, 32'h4};
    tbl[5] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_000C, 1'b1, 32'h4};
    tbl[6] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b1, 32'h4};
    tbl[7] = '{1'b1, 1'b1, 32'h0000_0102, 1'b1, 32'h0000_0010, 1'b1, 32'h8};
    tbl[8] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0100, 1'b0, 32'h8};
    tbl[9] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0104, 1'b1, 32'h100};

    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; pc_src = 1'b0;
    branch_target = '0; instr_ready = 1'b0;
    lat_fixed = 0; cur_lat = 0; delivered = 0;
    model_init();

    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed table, zero-wait memory
    for (int i = 0; i < 10; i++) begin
      cyc_begin(tbl[i].rdy, tbl[i].psc, tbl[i].tgt);
      chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      if (tbl[i].req)
        chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_ipc", i), instr_pc, tbl[i].ipc);
      chk($sformatf("tbl%0d_pc8", i), pc_plus8, tbl[i].ipc + 32'd8);
      if (tbl[i].vld)
        chk($sformatf("tbl%0d_instr", i), instr, mdata(tbl[i].ipc));
      cyc_end();
    end

    // Random traffic with random memory latency
    lat_fixed = -1;
    d0 = delivered;
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), $urandom);
    chk("random_progress", 32'(delivered - d0 > 50), 32'd1);

    // Consumer stall: queue fills to QDEPTH, requests stop, head holds
    lat_fixed = 0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0);
    cyc_begin(1'b0, 1'b0, 32'h0);
    chk("stall_start_valid", 32'(instr_valid), 32'd1);
    rec_pc = instr_pc;
    cyc_end();
    for (int i = 1; i < 10; i++) begin
      cyc_begin(1'b0, 1'b0, 32'h0);
      if (i == 9) begin
        chk("stall_depth", 32'(mq.size()), 32'(QDEPTH));
        chk("stall_req", 32'(imem_req), 32'd0);
        chk("stall_head", instr_pc, rec_pc);
      end
      cyc_end();
    end

    // Slow memory: ack three cycles after request -> one word every four cycles
    lat_fixed = 3;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 32'h0);
    d0 = delivered;
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 32'h0);
    chk("slow_rate", 32'(delivered - d0), 32'd10);

    // Redirect with a request in flight: stale word dropped, restart at aligned target
    for (int i = 0; i < 8 && wait_cnt != 1; i++) cyc(1'b1, 1'b0, 32'h0);
    cyc_begin(1'b1, 1'b1, 32'h0000_0102);
    chk("redir_pending_req", 32'(imem_req), 32'd1);
    chk("redir_pending_ack", 32'(imem_ack), 32'd0);
    cyc_end();
    got_addr = 0; got_valid = 0; first_addr = '0;
    for (int i = 0; i < 16 && !got_valid; i++) begin
      cyc_begin(1'b1, 1'b0, 32'h0);
      if (imem_req && !inflight && !stale && !got_addr) begin
        got_addr   = 1;
        first_addr = imem_addr;
      end
      if (instr_valid) begin
        got_valid = 1;
        chk("redir_first_pc", instr_pc, 32'h0000_0100);
      end
      cyc_end();
    end
    chk("redir_first_addr", first_addr, 32'h0000_0100);
    chk("redir_timeout", 32'(got_valid), 32'd1);

    // Reset with a request outstanding, late ack during reset and in IDLE
    for (int i = 0; i < 8 && wait_cnt != 1; i++) cyc(1'b1, 1'b0, 32'h0);
    reset = 1'b0; imem_ack = 1'b0; pc_src = 1'b0; instr_ready = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rst2_req", 32'(imem_req), 32'd0);
    chk("rst2_addr", imem_addr, RESET_PC);
    chk("rst2_valid", 32'(instr_valid), 32'd0);
`ifdef IFU_PERF_EN
    chk("rst2_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst2_flush_cnt", flush_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("idle_req", 32'(imem_req), 32'd0);
    chk("idle_valid", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    imem_ack = 1'b0;
    model_init();
    idle = 0;
    lat_fixed = 0;
    cyc_begin(1'b1, 1'b0, 32'h0);
    chk("post_rst_addr", imem_addr, RESET_PC);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    cyc_end();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
